// File: rtl/store_write_buffer_if.sv
// Bus bundle for the store write buffer: store-queue side, data-memory side and
// load-forwarding probe. The buffer uses the slave modport; its driver uses master.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface store_write_buffer_if;
  logic                   store_ready;
  logic [`ADDR_WIDTH-1:0] store_address;
  logic [`DATA_WIDTH-1:0] store_value;
  logic                   store_accept;
  logic                   wb_full;
  logic                   wb_empty;
  logic                   mem_req;
  logic [`ADDR_WIDTH-1:0] mem_addr;
  logic [`DATA_WIDTH-1:0] mem_wdata;
  logic                   mem_ack;
  logic                   fwd_load_valid;
  logic [`ADDR_WIDTH-1:0] fwd_load_addr;
  logic                   fwd_hit;
  logic [`DATA_WIDTH-1:0] fwd_data;

  modport master (
    output store_ready, store_address, store_value, mem_ack,
           fwd_load_valid, fwd_load_addr,
    input  store_accept, wb_full, wb_empty, mem_req, mem_addr, mem_wdata,
           fwd_hit, fwd_data
  );

  modport slave (
    input  store_ready, store_address, store_value, mem_ack,
           fwd_load_valid, fwd_load_addr,
    output store_accept, wb_full, wb_empty, mem_req, mem_addr, mem_wdata,
           fwd_hit, fwd_data
  );
endinterface

// File: rtl/store_write_buffer.sv
// Circular buffer of committed stores drained in order to data memory through a
// two-state request/ack FSM, with youngest-match forwarding to probing loads.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module store_write_buffer #(
  parameter int WB_DEPTH = 4,
  parameter int WB_SEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  store_write_buffer_if.slave   bus
);

  localparam int AW = `ADDR_WIDTH;
  localparam int DW = `DATA_WIDTH;
  localparam logic [WB_SEL:0] COUNT_FULL = (WB_SEL+1)'(WB_DEPTH);

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  state_t                           state_q,     state_d;
  logic [WB_DEPTH-1:0]              valid_q,     valid_d;
  logic [WB_DEPTH-1:0][AW-1:0]      addr_q,      addr_d;
  logic [WB_DEPTH-1:0][DW-1:0]      data_q,      data_d;
  logic [WB_SEL-1:0]                head_q,      head_d;
  logic [WB_SEL-1:0]                tail_q,      tail_d;
  logic [WB_SEL:0]                  count_q,     count_d;
  logic                             mem_req_q,   mem_req_d;
  logic [AW-1:0]                    mem_addr_q,  mem_addr_d;
  logic [DW-1:0]                    mem_wdata_q, mem_wdata_d;

  logic              full;
  logic              empty;
  logic              accept;
  logic              pop;
  logic              fwd_hit_c;
  logic [DW-1:0]     fwd_data_c;
  logic [WB_SEL-1:0] probe_idx;

  assign full   = (count_q == COUNT_FULL);
  assign empty  = (count_q == '0);
  assign accept = bus.store_ready && !full;

  // Drain FSM: one request outstanding at a time, returning to IDLE after each
  // ack so there is always one bubble cycle between memory writes.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          mem_req_d   = 1'b1;
          mem_addr_d  = addr_q[head_q];
          mem_wdata_d = data_q[head_q];
          state_d     = REQ;
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          pop       = 1'b1;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FIFO bookkeeping; a full buffer never accepts, so push and pop never hit the same slot.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + (WB_SEL+1)'(accept) - (WB_SEL+1)'(pop);
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + WB_SEL'(1);
    end
    if (accept) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = bus.store_address;
      data_d[tail_q]  = bus.store_value;
      tail_d          = tail_q + WB_SEL'(1);
    end
  end

  // Scan oldest to youngest so the last match left standing is the youngest store.
  always_comb begin
    fwd_hit_c  = 1'b0;
    fwd_data_c = '0;
    probe_idx  = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      probe_idx = head_q + WB_SEL'(i);
      if (bus.fwd_load_valid && valid_q[probe_idx] &&
          (addr_q[probe_idx] == bus.fwd_load_addr)) begin
        fwd_hit_c  = 1'b1;
        fwd_data_c = data_q[probe_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.store_accept = accept;
  assign bus.wb_full      = full;
  assign bus.wb_empty     = empty;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.fwd_hit      = fwd_hit_c;
  assign bus.fwd_data     = fwd_data_c;

endmodule

// File: tb/tb_store_write_buffer.sv
// Randomised and directed bench for store_write_buffer, checked every cycle
// against a queue-based model of the buffer, its drain order and forwarding.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_store_write_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = `ADDR_WIDTH;
  localparam int DW    = `DATA_WIDTH;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  store_write_buffer_if sbus ();

  store_write_buffer #(.WB_DEPTH(DEPTH), .WB_SEL(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sbus)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        model_q[$];
  bit            req_active;
  entry_t        req_entry;
  logic [AW-1:0] dut_writes[$];
  int            checks;
  int            failures;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Compare every output against the model while inputs are stable mid-cycle.
  task automatic checkOutput();
    bit            exp_hit;
    logic [DW-1:0] exp_fd;
    exp_hit = 1'b0;
    exp_fd  = '0;
    if (sbus.fwd_load_valid) begin
      foreach (model_q[i]) begin
        if (model_q[i].addr == sbus.fwd_load_addr) begin
          exp_hit = 1'b1;
          exp_fd  = model_q[i].data;
        end
      end
    end
    check("store_accept", sbus.store_accept, sbus.store_ready && (model_q.size() < DEPTH));
    check("wb_full",      sbus.wb_full,      model_q.size() == DEPTH);
    check("wb_empty",     sbus.wb_empty,     model_q.size() == 0);
    check("mem_req",      sbus.mem_req,      req_active);
    check("mem_addr",     sbus.mem_addr,     req_entry.addr);
    check("mem_wdata",    sbus.mem_wdata,    req_entry.data);
    check("fwd_hit",      sbus.fwd_hit,      exp_hit);
    check("fwd_data",     sbus.fwd_data,     exp_fd);
    if (sbus.mem_req && sbus.mem_ack && !reset) dut_writes.push_back(sbus.mem_addr);
  endtask

  // Model update at a clock edge: queue of pending stores, one request in flight.
  task automatic modelEdge();
    int     old_size;
    bit     acc;
    entry_t e;
    if (reset) begin
      model_q.delete();
      req_active = 1'b0;
      req_entry  = '0;
    end else begin
      old_size = model_q.size();
      acc      = sbus.store_ready && (old_size < DEPTH);
      if (req_active) begin
        if (sbus.mem_ack) begin
          void'(model_q.pop_front());
          req_active = 1'b0;
        end
      end else if (old_size > 0) begin
        req_active = 1'b1;
        req_entry  = model_q[0];
      end
      if (acc) begin
        e.addr = sbus.store_address;
        e.data = sbus.store_value;
        model_q.push_back(e);
      end
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit rdy, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input bit ack, input bit pv,
                               input logic [AW-1:0] pa);
    reset               = rst;
    sbus.store_ready    = rdy;
    sbus.store_address  = a;
    sbus.store_value    = d;
    sbus.mem_ack        = ack;
    sbus.fwd_load_valid = pv;
    sbus.fwd_load_addr  = pa;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic idle(input bit ack);
    applyStimulus(1'b0, 1'b0, '0, '0, ack, 1'b0, '0);
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    applyStimulus(1'b0, 1'b1, a, d, 1'b0, 1'b0, '0);
  endtask

  task automatic drain();
    for (int k = 0; k < 64 && (model_q.size() > 0 || req_active); k++) idle(1'b1);
    check("drain_empty", sbus.wb_empty, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sent;
    checks   = 0;
    failures = 0;
    reset               = 1'b1;
    sbus.store_ready    = 1'b0;
    sbus.store_address  = '0;
    sbus.store_value    = '0;
    sbus.mem_ack        = 1'b0;
    sbus.fwd_load_valid = 1'b0;
    sbus.fwd_load_addr  = '0;
    repeat (2) @(posedge clk);
    modelEdge();
    #1;

    // Reset values
    check("rst_empty",    sbus.wb_empty,  1'b1);
    check("rst_full",     sbus.wb_full,   1'b0);
    check("rst_mem_req",  sbus.mem_req,   1'b0);
    check("rst_mem_addr", sbus.mem_addr,  '0);
    check("rst_fwd_hit",  sbus.fwd_hit,   1'b0);
    check("rst_fwd_data", sbus.fwd_data,  '0);
    sbus.store_ready = 1'b1;
    #1;
    check("rst_accept",   sbus.store_accept, 1'b1);

    // Single store: request one edge after acceptance, stable while unacked
    store(32'h100, 32'hAA);
    check("single_req_early", sbus.mem_req, 1'b0);
    idle(1'b0);
    check("single_req",   sbus.mem_req,   1'b1);
    check("single_addr",  sbus.mem_addr,  32'h100);
    check("single_wdata", sbus.mem_wdata, 32'hAA);
    for (int k = 0; k < 3; k++) begin
      idle(1'b0);
      check("single_hold_req",  sbus.mem_req,  1'b1);
      check("single_hold_addr", sbus.mem_addr, 32'h100);
    end
    idle(1'b1);
    check("single_done_empty", sbus.wb_empty, 1'b1);
    check("single_done_req",   sbus.mem_req,  1'b0);

    // Fill: full buffer refuses a store even while popping
    for (int k = 0; k < 4; k++) store(32'h1000 + 32'(k * 4), 32'h50 + 32'(k));
    check("fill_full", sbus.wb_full, 1'b1);
    sbus.store_ready   = 1'b1;
    sbus.store_address = 32'h999;
    sbus.mem_ack       = 1'b1;
    #1;
    check("fill_no_accept", sbus.store_accept, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h999, 32'h99, 1'b1, 1'b0, '0);
    check("fill_after_pop_full", sbus.wb_full, 1'b0);
    drain();

    // Order and wrap: six stores, ack every third cycle
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    dut_writes.delete();
    sent = 0;
    for (int c = 0; c < 120 && (sent < 6 || model_q.size() > 0 || req_active); c++) begin
      bit rdy;
      bit acc;
      rdy = (sent < 6);
      acc = rdy && (model_q.size() < DEPTH);
      applyStimulus(1'b0, rdy, 32'((sent + 1) * 16), 32'hA0 + 32'(sent), (c % 3) == 2, 1'b0, '0);
      if (acc) sent++;
    end
    check("wrap_count", dut_writes.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < dut_writes.size()) check("wrap_order", dut_writes[i], 32'((i + 1) * 16));

    // Forwarding: youngest match wins, miss gives zero, same-cycle store invisible
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    store(32'h200, 32'h11);
    store(32'h200, 32'h22);
    sbus.store_ready    = 1'b0;
    sbus.fwd_load_valid = 1'b1;
    sbus.fwd_load_addr  = 32'h200;
    #1;
    check("fwd_young_hit",  sbus.fwd_hit,  1'b1);
    check("fwd_young_data", sbus.fwd_data, 32'h22);
    sbus.fwd_load_addr = 32'h204;
    #1;
    check("fwd_miss_hit",  sbus.fwd_hit,  1'b0);
    check("fwd_miss_data", sbus.fwd_data, 32'h0);
    sbus.store_ready   = 1'b1;
    sbus.store_address = 32'h300;
    sbus.store_value   = 32'h33;
    sbus.fwd_load_addr = 32'h300;
    #1;
    check("fwd_same_cycle", sbus.fwd_hit, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h300, 32'h33, 1'b0, 1'b1, 32'h300);
    sbus.store_ready = 1'b0;
    #1;
    check("fwd_next_cycle", sbus.fwd_data, 32'h33);
    drain();

    // Simultaneous accept and pop keeps the count
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    store(32'h400, 32'h44);
    store(32'h500, 32'h55);
    check("sim_req_addr", sbus.mem_addr, 32'h400);
    applyStimulus(1'b0, 1'b1, 32'h600, 32'h66, 1'b1, 1'b0, '0);
    check("sim_not_empty", sbus.wb_empty, 1'b0);
    check("sim_req_drop",  sbus.mem_req,  1'b0);
    idle(1'b0);
    check("sim_next_addr",  sbus.mem_addr,  32'h500);
    check("sim_next_wdata", sbus.mem_wdata, 32'h55);
    store(32'h700, 32'h77);
    check("sim_count3_full", sbus.wb_full, 1'b0);
    store(32'h800, 32'h88);
    check("sim_count4_full", sbus.wb_full, 1'b1);

    // Reset mid-request with three entries
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0);
    store(32'h900, 32'h1);
    store(32'h904, 32'h2);
    store(32'h908, 32'h3);
    check("rstmid_req", sbus.mem_req, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, 1'b0, '0);
    check("rstmid_req_drop", sbus.mem_req,  1'b0);
    check("rstmid_empty",    sbus.wb_empty, 1'b1);
    check("rstmid_addr",     sbus.mem_addr, 32'h0);
    for (int k = 0; k < 4; k++) begin
      idle(1'b1);
      check("rstmid_quiet", sbus.mem_req, 1'b0);
    end

    // Random traffic over a small address set so forwarding hits often
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 1) == 1),
                    32'($urandom_range(0, 7) * 4),
                    $urandom(),
                    ($urandom_range(0, 9) < 4),
                    ($urandom_range(0, 1) == 1),
                    32'($urandom_range(0, 7) * 4));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/store_write_buffer.md
STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

Interface
REQ-001 The block SHALL use parameter WB_DEPTH, default 4, number of buffered committed stores (power of two).
REQ-002 The block SHALL use parameter WB_SEL, default 2, index width, equal to log2(WB_DEPTH).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have port store_ready, input, 1 bit, store queue presents a committed store this cycle.
REQ-006 The block SHALL have port store_address, input, `ADDR_WIDTH bits, address of the presented store.
REQ-007 The block SHALL have port store_value, input, `DATA_WIDTH bits, data of the presented store.
REQ-008 The block SHALL have port store_accept, output, 1 bit, the presented store is taken at this edge.
REQ-009 The block SHALL have port wb_full, output, 1 bit, count == WB_DEPTH.
REQ-010 The block SHALL have port wb_empty, output, 1 bit, count == 0.
REQ-011 The block SHALL have port mem_req, output, 1 bit, data-memory write request.
REQ-012 The block SHALL have port mem_addr, output, `ADDR_WIDTH bits, write address.
REQ-013 The block SHALL have port mem_wdata, output, `DATA_WIDTH bits, write data.
REQ-014 The block SHALL have port mem_ack, input, 1 bit, memory completes the write at this edge.
REQ-015 The block SHALL have port fwd_load_valid, input, 1 bit, a load is probing for forwarding.
REQ-016 The block SHALL have port fwd_load_addr, input, `ADDR_WIDTH bits, address of the probing load.
REQ-017 The block SHALL have port fwd_hit, output, 1 bit, a buffered store matches the load address.
REQ-018 The block SHALL have port fwd_data, output, `DATA_WIDTH bits, forwarded data.

Function
REQ-019 Storage SHALL be a circular FIFO: per-entry valid/addr/data, head, tail (WB_SEL bits, wrap WB_DEPTH-1 -> 0), count (WB_SEL+1 bits).
REQ-020 store_accept SHALL be combinational, = store_ready && !wb_full; on accept, entry[tail] is written, valid set, and tail advances at the edge.
REQ-021 A full buffer SHALL NOT accept a store even if a pop occurs in the same cycle.
REQ-022 Simultaneous accept and pop SHALL leave count unchanged while head and tail both advance.
REQ-023 wb_full and wb_empty SHALL be combinational decodes of the count register.
REQ-024 The drain FSM SHALL have states IDLE and REQ.
REQ-025 In IDLE with count > 0, the FSM SHALL register entry[head] addr/data into mem_addr/mem_wdata, set mem_req, and enter REQ at the next edge.
REQ-026 In REQ, mem_req, mem_addr and mem_wdata SHALL stay stable until the edge at which mem_ack = 1 is sampled.
REQ-027 On that edge, the FSM SHALL pop head (clear valid, advance head, decrement count), clear mem_req, and return to IDLE, giving one bubble cycle between writes.
REQ-028 mem_ack SHALL be ignored in IDLE.
REQ-029 Latency: a store accepted at edge N into an empty buffer SHALL see mem_req = 1 after edge N+1.
REQ-030 Forwarding SHALL be combinational: fwd_hit = fwd_load_valid && some valid entry has an address exactly equal to fwd_load_addr (full-width compare).
REQ-031 The in-flight head entry SHALL count as a match candidate until it is popped.
REQ-032 On multiple matches, fwd_data SHALL be the data of the youngest entry (closest to tail).
REQ-033 A store being accepted in the same cycle SHALL NOT be visible to forwarding.
REQ-034 When there is no hit, fwd_data SHALL be 0.
REQ-035 Stores SHALL drain to memory strictly in acceptance order.

Reset
REQ-036 When reset = 1 at an edge, head, tail and count SHALL become 0, all valid bits SHALL clear, the FSM SHALL go to IDLE, and mem_req, mem_addr and mem_wdata SHALL become 0.
REQ-037 Reset asserted mid-handshake SHALL drop mem_req after that edge, discard all buffered stores, and ignore any mem_ack in that cycle.
REQ-038 After reset, outputs SHALL be wb_empty = 1, wb_full = 0, store_accept = store_ready, fwd_hit = 0 and fwd_data = 0.

Verification
REQ-039 Single store: accept addr 0x100, data 0xAA at edge N -> mem_req = 1 with mem_addr 0x100 after edge N+1; mem_ack held 0 for 3 cycles keeps outputs stable; ack -> wb_empty = 1 and mem_req = 0.
REQ-040 Fill: 4 back-to-back stores with mem_ack = 0 -> wb_full = 1 and a fifth store sees store_accept = 0 even in a cycle with mem_ack = 1.
REQ-041 Order and wrap: 6 stores (0x10..0x60) with ack every 3 cycles -> memory observes 0x10..0x60 in order; tail wraps 3 -> 0 with no loss.
REQ-042 Forwarding: buffer holds 0x200/0x11 then 0x200/0x22 -> probe 0x200 gives fwd_hit = 1, fwd_data 0x22; probe 0x204 gives hit 0, data 0.
REQ-043 Simultaneous: count = 2, accept and ack in the same cycle -> count stays 2 and the next request carries the second-oldest store.
REQ-044 Reset mid-REQ with 3 entries -> after the edge, mem_req = 0, wb_empty = 1, and no further requests issue.
